// File: rtl/square_if.sv
// Operand/result bus for the iterative squarer; master drives the request, slave is the squarer.
// The done_o pulse exists only when SQUARE_DONE_EN is defined.
interface square_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   x_bi;
  logic               start_i;
  logic               busy_o;
  logic [2*WIDTH-1:0] y_bo;
`ifdef SQUARE_DONE_EN
  logic               done_o;

  modport master (output x_bi, output start_i, input busy_o, input y_bo, input done_o);
  modport slave  (input x_bi, input start_i, output busy_o, output y_bo, output done_o);
`else
  modport master (output x_bi, output start_i, input busy_o, input y_bo);
  modport slave  (input x_bi, input start_i, output busy_o, output y_bo);
`endif
endinterface

// File: rtl/square.sv
// Sequential squarer: y = x*x by shift-and-add, one multiplier bit per clock, fixed WIDTH-cycle latency.
// Optional one-cycle completion pulse on done_o when SQUARE_DONE_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for start_i, result held on y_bo
// S_WORK | iterating over the latched operand bits
module square #(
  parameter int WIDTH = 8
) (
  input  logic     clk_i,
  input  logic     rst_i,
  square_if.slave  bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_WORK} state_t;

  state_t          state_q;
  logic [PW-1:0]   a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   acc_d;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   y_q;
  logic            busy_q;
`ifdef SQUARE_DONE_EN
  logic            done_q;
`endif

  // Accumulator including this cycle's partial product, so the last bit lands in y on completion.
  always_comb begin
    acc_d = acc_q;
    if (b_q[0]) acc_d = acc_q + a_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
`ifdef SQUARE_DONE_EN
      done_q  <= 1'b0;
`endif
    end else begin
`ifdef SQUARE_DONE_EN
      done_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            a_q     <= {{WIDTH{1'b0}}, bus.x_bi};
            b_q     <= bus.x_bi;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_WORK;
          end
        end
        S_WORK: begin
          acc_q <= acc_d;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            y_q     <= acc_d;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
`ifdef SQUARE_DONE_EN
            done_q  <= 1'b1;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.y_bo   = y_q;
`ifdef SQUARE_DONE_EN
  assign bus.done_o = done_q;
`endif
endmodule

// File: tb/tb_square.sv
// Bench for square: a cycle-level reference model (countdown + multiply) checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_square;
  localparam int WIDTH = 8;
  localparam int PW = 2 * WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  square_if #(.WIDTH(WIDTH)) sif ();

  square #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation is a WIDTH-cycle countdown ending in y = x*x.
  logic          m_busy;
  int            m_rem;
  int            m_x;
  logic [PW-1:0] m_y;
  logic          m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_rem = 0; m_x = 0; m_y = '0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (sif.start_i) begin
          m_busy = 1'b1; m_x = int'(sif.x_bi); m_rem = WIDTH;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0; m_y = PW'(m_x * m_x); m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_vs_model", 64'(sif.busy_o), 64'(m_busy));
      chk("y_vs_model", 64'(sif.y_bo), 64'(m_y));
`ifdef SQUARE_DONE_EN
      chk("done_vs_model", 64'(sif.done_o), 64'(m_done));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_op(input int x);
    sif.x_bi = WIDTH'(x); sif.start_i = 1'b1;
    step(1);
    sif.start_i = 1'b0;
    step(WIDTH + 1);
  endtask

  int n;
  int highs;
  int dones;
  int sweep_x[17];

  initial begin
    sif.x_bi = '0; sif.start_i = 1'b0;
    step(2);
    chk("reset_busy", 64'(sif.busy_o), 64'd0);
    chk("reset_y", 64'(sif.y_bo), 64'd0);
    rst_n = 1'b1;
    step(1);

    // Basic: x=15, one-cycle start pulse
    sif.x_bi = 8'd15; sif.start_i = 1'b1;
    step(1);
    sif.start_i = 1'b0;
    n = 0;
    while (sif.busy_o && n < 20) begin n++; step(1); end
    chk("basic_busy_cycles", 64'(n), 64'd8);
    chk("basic_y", 64'(sif.y_bo), 64'd225);
    step(20);
    chk("basic_y_held", 64'(sif.y_bo), 64'd225);

    // Operand changes during WORK are ignored
    sif.x_bi = 8'd12; sif.start_i = 1'b1;
    step(1);
    sif.start_i = 1'b0; sif.x_bi = 8'd200;
    step(WIDTH + 1);
    chk("stable_y", 64'(sif.y_bo), 64'd144);

    // Async reset mid-operation
    run_op(100);
    chk("pre_reset_y", 64'(sif.y_bo), 64'd10000);
    sif.x_bi = 8'd9; sif.start_i = 1'b1;
    step(1);
    sif.start_i = 1'b0;
    step(3);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", 64'(sif.busy_o), 64'd0);
    chk("midreset_y", 64'(sif.y_bo), 64'd0);
    step(1);
    rst_n = 1'b1;
    run_op(9);
    chk("after_reset_y", 64'(sif.y_bo), 64'd81);

    // Sweep under reset-then-held-start pattern
    for (int i = 0; i < 16; i++) sweep_x[i] = i;
    sweep_x[16] = 255;
    sif.start_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      sif.x_bi = WIDTH'(sweep_x[i]);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(15);
      chk($sformatf("sweep_x%0d", sweep_x[i]), 64'(sif.y_bo), 64'(sweep_x[i] * sweep_x[i]));
    end
    chk("sweep_extreme_255", 64'(sif.y_bo), 64'd65025);
    sif.start_i = 1'b0;
    step(WIDTH + 2);

    // Continuous start with x=7
    sif.x_bi = 8'd7; sif.start_i = 1'b1;
    step(1);
    highs = 0; dones = 0;
    for (int c = 0; c < 27; c++) begin
      if (sif.busy_o) highs++;
`ifdef SQUARE_DONE_EN
      if (sif.done_o) begin
        dones++;
        chk("cont_done_when_idle", 64'(sif.busy_o), 64'd0);
      end
`endif
      if (c % 9 == 8) begin
        chk("cont_idle_slot", 64'(sif.busy_o), 64'd0);
        chk("cont_y", 64'(sif.y_bo), 64'd49);
      end
      step(1);
    end
    chk("cont_busy_highs", 64'(highs), 64'd24);
`ifdef SQUARE_DONE_EN
    chk("cont_done_count", 64'(dones), 64'd3);
`endif
    sif.start_i = 1'b0;
    step(WIDTH + 2);
    chk("final_y", 64'(sif.y_bo), 64'd49);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/square.md
# square

Sequential integer squarer: computes y = x·x for an unsigned WIDTH-bit operand using an iterative shift-and-add datapath, one multiplier bit per clock. It is the inverse companion of the `sqrt` block in the arithmetic library, with the same start/busy handshake and bus naming. Benches and datapaths chain the two blocks (x → `square` → `sqrt` → x) for round-trip checking. The result register holds its value between operations.

## Interface
- WIDTH, 8, operand width in bits; result is 2·WIDTH bits; legal range 2..16
- clk_i  input  1  clock; all state changes on the rising edge
- rst_i  input  1  reset, asynchronous, active-low; clears all state immediately on assertion
- x_bi  input  WIDTH  unsigned operand; sampled only on the accepting edge
- start_i  input  1  level request; sampled only while idle
- busy_o  output  1  high while an operation is in progress
- y_bo  output  2·WIDTH  unsigned result x·x; registered, held until the next completion
- done_o  output  1  one-cycle completion pulse; present only with SQUARE_DONE_EN

## Operation
- States:
  - IDLE (reset state).
  - WORK.
- IDLE, start_i=1 on an edge (the accepting edge):
  - a ← zero-extended x_bi (2·WIDTH bits), b ← x_bi, acc ← 0, cnt ← 0.
  - → WORK; busy_o ← 1.
- IDLE, start_i=0: hold all state; y_bo unchanged.
- WORK, each edge:
  - If b[0] = 1: acc ← acc + a.
  - a ← a << 1; b ← b >> 1; cnt ← cnt + 1.
- WORK, edge with cnt = WIDTH−1:
  - y_bo ← final acc, including that cycle's addition.
  - → IDLE; busy_o ← 0.
- Arithmetic:
  - acc and a are 2·WIDTH bits; no overflow is possible (max (2^WIDTH−1)^2 fits).
  - cnt is ceil(log2(WIDTH)) bits.
- Fixed latency: no early exit when b becomes zero.
- x_bi and start_i changes during WORK are ignored; the latched operand is used.
- y_bo changes only on a completion edge or on reset. A new start does not clear it.
- start_i held high continuously: operations repeat back-to-back, with one IDLE cycle between them.
- Reset asserted mid-operation:
  - Immediately: state IDLE, busy_o=0, y_bo=0, done_o=0, internal registers 0.
  - The partial result is discarded.
  - After release, a new start is required; if start_i is already high, the first edge starts a new operation.

## Timing
- Reset values: busy_o=0, y_bo=0, done_o=0.
- Accepting edge E:
  - busy_o=1 from E through E+WIDTH−1.
  - busy_o=0 and y_bo valid from edge E+WIDTH.
  - Latency is WIDTH cycles (8 at default).
- Back-to-back: with start_i held high, the next accepting edge is E+WIDTH+1.
  - Period is WIDTH+1 cycles.
  - busy_o is low for exactly one cycle between operations.
- y_bo is glitch-free: register output only.

## Configuration
- SQUARE_DONE_EN defined:
  - done_o port exists.
  - It is high for exactly the one cycle following the completion edge (E+WIDTH to E+WIDTH+1).
  - It is cleared by reset.
- SQUARE_DONE_EN undefined:
  - done_o port is absent.
  - Completion is detected by the falling edge of busy_o only.
  - All other behaviour is identical.

## Test plan
- Basic operation, WIDTH=8:
  - Stimulus: reset, then x_bi=15 with start_i pulsed for one cycle.
  - Required response: busy_o high exactly 8 cycles; y_bo=225 after; y_bo stays 225 for the following 20 idle cycles.
- Sweep:
  - Stimulus: x=0..15, each run under the reset/start pattern used for sqrt (rst low 1 cycle, then start held).
  - Required response: y_bo = x² for every x, checked 15 cycles after release.
  - Extremes: x=0 → 0; x=255 → 65025.
- Operand stability:
  - Stimulus: x_bi=12 accepted, then x_bi driven to 200 during the busy cycles.
  - Required response: y_bo=144.
- Reset mid-operation:
  - Setup: run x=100 to completion, so y_bo=10000.
  - Stimulus: start x=9 and assert rst_i low at busy cycle 4.
  - Required response: busy_o=0 and y_bo=0 immediately, with no clock needed.
  - After release: x=9 yields 81.
- Continuous start:
  - Stimulus: start_i held high with x=7.
  - Required response: busy_o pattern is 8 high, 1 low, repeating; y_bo=49 throughout once the first result lands.
  - With SQUARE_DONE_EN: done_o pulses once per 9-cycle period, in the busy-low cycle.
